hrm_mbox_array: RTL and testbench
=================================

// Module: hrm_mbox_array
// PURPOSE
//  Parametrised multi-channel mailbox FIFO array for the HRM-CPU I/O subsystem; generalises the single INBOX/OUTBOX pair.
//  Holds NCH independent FIFOs of DEPTH=2**LGFLEN words, each W bits, behind one shared write port and one shared read port.
//  Each port selects its channel per cycle. Per-channel flags, sticky error flags and flush are provided.
//  A dump port exposes any word of any channel for the debug screen.
// PARAMETERS
//  W       8  data word width in bits
//  LGFLEN  5  log2 of per-channel depth (DEPTH = 2**LGFLEN)
//  NCH     2  number of channels (>=1); CHW = max(1,$clog2(NCH))
// PORTS
//  clk          in   1         system clock, rising edge
//  i_rst        in   1         asynchronous, active-low reset
//  i_wr         in   1         push request
//  i_wr_ch      in   CHW       channel targeted by push
//  i_data       in   W         push data
//  i_rd         in   1         pop request
//  i_rd_ch      in   CHW       channel targeted by pop and by o_data
//  o_data       out  W         head word of channel i_rd_ch (first-word-fall-through)
//  o_empty_n    out  NCH       per-channel not-empty flag
//  o_full       out  NCH       per-channel full flag (level == DEPTH)
//  o_ovf        out  NCH       sticky: push attempted while full
//  o_udf        out  NCH       sticky: pop attempted while empty
//  i_flush      in   NCH       synchronous per-channel flush mask
//  i_clr_err    in   1         synchronous clear of all o_ovf/o_udf bits
//  i_dmp_ch     in   CHW       dump channel select
//  i_dmp_pos    in   LGFLEN    dump position, 0 = head (oldest word)
//  o_dmp_data   out  W         word at i_dmp_pos of i_dmp_ch
//  o_dmp_valid  out  1         1 iff i_dmp_ch < NCH and i_dmp_pos < level(i_dmp_ch)
// BEHAVIOUR
//  Per-channel state: wr_ptr, rd_ptr (LGFLEN bits, wrap mod DEPTH), level (LGFLEN+1 bits, 0..DEPTH).
//  Storage: register array, NCH*DEPTH words; contents are not reset.
//  Reset (i_rst=0, async): all pointers/levels=0, o_empty_n=0, o_full=0, o_ovf=0, o_udf=0.
//  Push is accepted at the clk edge iff i_wr=1, i_wr_ch<NCH, !full and no flush on that channel.
//    On accept: mem[ch][wr_ptr]<=i_data; wr_ptr++.
//    If full: data is dropped, o_ovf[ch]<=1, state is unchanged. A pop in the same cycle does not make room.
//  Pop is accepted iff i_rd=1, i_rd_ch<NCH, level>0 and no flush on that channel; rd_ptr++.
//    If empty: the pop is ignored and o_udf[ch]<=1. A push in the same cycle is still accepted.
//  Push and pop on the same channel in the same cycle, both accepted: level unchanged, both pointers advance.
//  Different channels are fully independent in the same cycle.
//  Channel index >= NCH: the request is ignored, no flag is set, o_data=0.
//  Flush (i_flush[c]=1): next edge wr_ptr=rd_ptr=level=0 for channel c.
//    Flush dominates a push/pop to c in the same cycle; that push/pop is discarded and sets no flag.
//  i_clr_err: clears all sticky bits. Any error event in the same cycle wins, and its bit reads 1 next cycle.
//  Flags are registered and derived from the next level: o_empty_n=(level!=0), o_full=(level==DEPTH).
//    A push into an empty channel shows o_empty_n=1 one cycle after the edge.
//  o_data = mem[i_rd_ch][rd_ptr], combinational from registered state; zero-cycle latency from i_rd_ch.
//    The value is undefined-but-stable when the channel is empty; benches must not check it then.
//  o_dmp_data = mem[i_dmp_ch][(rd_ptr+i_dmp_pos) mod DEPTH], combinational.
//    Equals 0 when o_dmp_valid=0 or i_dmp_ch >= NCH.
//  A read-during-write on the same address returns the old word; it can only occur when level==0.
// TESTING
//  T1 reset: drop i_rst mid-traffic with ch0 holding 3 words -> same cycle o_empty_n=0, o_full=0, o_ovf=o_udf=0, o_dmp_valid=0.
//  T2 fill/wrap (LGFLEN=5, NCH=2): push 0..31 to ch1 -> o_full[1]=1.
//     Push 0x55 -> o_ovf[1]=1 and the data is dropped.
//     Pop 10, push 10 more -> pops return 10..31 then the new words in order across the wrap.
//  T3 simultaneous ops: ch0 holds 1 word (0x11); in one cycle push 0x22 to ch0 and pop ch0 -> level stays 1, o_data=0x22 next cycle.
//     Push ch1 + pop ch0 in one cycle -> each channel is updated independently.
//  T4 empty/underflow: pop empty ch0 while pushing 0x7F to ch0 -> o_udf[0]=1, level=1, o_data=0x7F.
//     Then i_clr_err -> o_udf=0.
//  T5 flush: ch1 holds 5 words; assert i_flush=2'b10 with push to ch1 -> level(ch1)=0, o_ovf/o_udf unchanged.
//     ch0 contents are untouched.
//  T6 dump: ch0 holds A0,A1,A2 after a wrap -> i_dmp_pos=0..2 returns A0..A2 with valid=1.
//     pos=3 -> valid=0 and data=0. i_dmp_ch=2 with NCH=2 -> valid=0.

Source files
------------

// File: rtl/hrm_mbox_array_if.sv
// Bus bundle for hrm_mbox_array: shared push/pop ports, per-channel flags,
// flush/error control and the debug dump port.
interface hrm_mbox_array_if #(
   parameter int W      = 8,
   parameter int LGFLEN = 5,
   parameter int NCH    = 2,
   parameter int CHW    = (NCH > 1) ? $clog2(NCH) : 1
);
   logic              i_wr;
   logic [CHW-1:0]    i_wr_ch;
   logic [W-1:0]      i_data;
   logic              i_rd;
   logic [CHW-1:0]    i_rd_ch;
   logic [W-1:0]      o_data;
   logic [NCH-1:0]    o_empty_n;
   logic [NCH-1:0]    o_full;
   logic [NCH-1:0]    o_ovf;
   logic [NCH-1:0]    o_udf;
   logic [NCH-1:0]    i_flush;
   logic              i_clr_err;
   logic [CHW-1:0]    i_dmp_ch;
   logic [LGFLEN-1:0] i_dmp_pos;
   logic [W-1:0]      o_dmp_data;
   logic              o_dmp_valid;

   modport master (
      output i_wr, i_wr_ch, i_data, i_rd, i_rd_ch, i_flush, i_clr_err, i_dmp_ch, i_dmp_pos,
      input  o_data, o_empty_n, o_full, o_ovf, o_udf, o_dmp_data, o_dmp_valid
   );

   modport slave (
      input  i_wr, i_wr_ch, i_data, i_rd, i_rd_ch, i_flush, i_clr_err, i_dmp_ch, i_dmp_pos,
      output o_data, o_empty_n, o_full, o_ovf, o_udf, o_dmp_data, o_dmp_valid
   );
endinterface

// File: rtl/hrm_mbox_array.sv
// NCH independent first-word-fall-through mailbox FIFOs sharing one push port,
// one pop port and a combinational debug dump port.
module hrm_mbox_array #(
   parameter int W      = 8,
   parameter int LGFLEN = 5,
   parameter int NCH    = 2
) (
   input logic              clk,
   input logic              i_rst,
   hrm_mbox_array_if.slave  bus
);
   localparam int DEPTH = 1 << LGFLEN;
   localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;

   logic [W-1:0] mem [NCH][DEPTH];

   logic [NCH-1:0][LGFLEN-1:0] wr_ptr_all;
   logic [NCH-1:0][LGFLEN-1:0] rd_ptr_all;
   logic [NCH-1:0][LGFLEN:0]   level_all;
   logic [NCH-1:0]             push_ok;

   logic              wr_ch_ok;
   logic              rd_ch_ok;
   logic              dmp_ch_ok;
   logic [LGFLEN:0]   dmp_level;
   logic [LGFLEN-1:0] dmp_addr;

   assign wr_ch_ok  = int'(bus.i_wr_ch) < NCH;
   assign rd_ch_ok  = int'(bus.i_rd_ch) < NCH;
   assign dmp_ch_ok = int'(bus.i_dmp_ch) < NCH;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [LGFLEN-1:0] wr_ptr_reg;
         logic [LGFLEN-1:0] rd_ptr_reg;
         logic [LGFLEN:0]   level_reg;
         logic [LGFLEN:0]   level_next;
         logic              empty_n_reg;
         logic              full_reg;
         logic              ovf_reg;
         logic              udf_reg;
         logic              wr_hit;
         logic              rd_hit;
         logic              flush;
         logic              pop_ok;
         logic              ovf_set;
         logic              udf_set;

         assign flush  = bus.i_flush[gi];
         assign wr_hit = bus.i_wr && wr_ch_ok && (bus.i_wr_ch == CHW'(gi)) && !flush;
         assign rd_hit = bus.i_rd && rd_ch_ok && (bus.i_rd_ch == CHW'(gi)) && !flush;

         // Fullness is judged before any same-cycle pop, so a pop never makes room.
         assign push_ok[gi] = wr_hit && !full_reg;
         assign pop_ok      = rd_hit && empty_n_reg;
         assign ovf_set     = wr_hit && full_reg;
         assign udf_set     = rd_hit && !empty_n_reg;

         assign level_next = flush ? '0
                           : level_reg + {{LGFLEN{1'b0}}, push_ok[gi]} - {{LGFLEN{1'b0}}, pop_ok};

         always_ff @(posedge clk or negedge i_rst) begin
            if (!i_rst) begin
               wr_ptr_reg  <= '0;
               rd_ptr_reg  <= '0;
               level_reg   <= '0;
               empty_n_reg <= 1'b0;
               full_reg    <= 1'b0;
               ovf_reg     <= 1'b0;
               udf_reg     <= 1'b0;
            end else begin
               level_reg   <= level_next;
               empty_n_reg <= (level_next != '0);
               full_reg    <= (level_next == (LGFLEN+1)'(DEPTH));
               if (flush) begin
                  wr_ptr_reg <= '0;
                  rd_ptr_reg <= '0;
               end else begin
                  if (push_ok[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                  if (pop_ok)      rd_ptr_reg <= rd_ptr_reg + 1'b1;
               end
               // A same-cycle error event outranks the clear.
               ovf_reg <= (bus.i_clr_err ? 1'b0 : ovf_reg) | ovf_set;
               udf_reg <= (bus.i_clr_err ? 1'b0 : udf_reg) | udf_set;
            end
         end

         assign wr_ptr_all[gi]    = wr_ptr_reg;
         assign rd_ptr_all[gi]    = rd_ptr_reg;
         assign level_all[gi]     = level_reg;
         assign bus.o_empty_n[gi] = empty_n_reg;
         assign bus.o_full[gi]    = full_reg;
         assign bus.o_ovf[gi]     = ovf_reg;
         assign bus.o_udf[gi]     = udf_reg;
      end
   endgenerate

   // At most one push is accepted per cycle, so the storage needs a single write port.
   always_ff @(posedge clk) begin
      if (|push_ok)
         mem[bus.i_wr_ch][wr_ptr_all[bus.i_wr_ch]] <= bus.i_data;
   end

   assign bus.o_data = rd_ch_ok ? mem[bus.i_rd_ch][rd_ptr_all[bus.i_rd_ch]] : '0;

   assign dmp_level       = dmp_ch_ok ? level_all[bus.i_dmp_ch] : '0;
   assign dmp_addr        = rd_ptr_all[bus.i_dmp_ch] + bus.i_dmp_pos;
   assign bus.o_dmp_valid = dmp_ch_ok && ({1'b0, bus.i_dmp_pos} < dmp_level);
   assign bus.o_dmp_data  = bus.o_dmp_valid ? mem[bus.i_dmp_ch][dmp_addr] : '0;
endmodule

// File: tb/tb_hrm_mbox_array.sv
// Directed bench for hrm_mbox_array. Three channels are instantiated so the
// 2-bit channel field can express an out-of-range index (3).
module tb_hrm_mbox_array;
   localparam int W      = 8;
   localparam int LGFLEN = 5;
   localparam int NCH    = 3;
   localparam int CHW    = 2;

   logic clk;
   logic i_rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   hrm_mbox_array_if #(.W(W), .LGFLEN(LGFLEN), .NCH(NCH), .CHW(CHW)) bus ();

   hrm_mbox_array #(.W(W), .LGFLEN(LGFLEN), .NCH(NCH)) dut (
      .clk   (clk),
      .i_rst (i_rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s got=%0h", tag, got);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int ch, input logic [W-1:0] d);
      bus.i_wr    = 1'b1;
      bus.i_wr_ch = CHW'(ch);
      bus.i_data  = d;
      cyc();
      bus.i_wr    = 1'b0;
   endtask

   task automatic pop(input int ch);
      bus.i_rd    = 1'b1;
      bus.i_rd_ch = CHW'(ch);
      cyc();
      bus.i_rd    = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input int ch, input logic [W-1:0] exp);
      bus.i_rd_ch = CHW'(ch);
      #1;
      check(tag, 32'(bus.o_data), 32'(exp));
      pop(ch);
   endtask

   task automatic dmp_chk(input string tag, input int ch, input int pos,
                          input logic vexp, input logic [W-1:0] dexp);
      bus.i_dmp_ch  = CHW'(ch);
      bus.i_dmp_pos = LGFLEN'(pos);
      #1;
      check({tag, "_v"}, 32'(bus.o_dmp_valid), 32'(vexp));
      check({tag, "_d"}, 32'(bus.o_dmp_data), 32'(dexp));
   endtask

   initial begin
      i_rst         = 1'b0;
      bus.i_wr      = 1'b0;
      bus.i_wr_ch   = '0;
      bus.i_data    = '0;
      bus.i_rd      = 1'b0;
      bus.i_rd_ch   = '0;
      bus.i_flush   = '0;
      bus.i_clr_err = 1'b0;
      bus.i_dmp_ch  = '0;
      bus.i_dmp_pos = '0;
      cyc();
      cyc();
      i_rst = 1'b1;
      cyc();
      check("rst_empty_n", 32'(bus.o_empty_n), 32'h0);
      check("rst_full",    32'(bus.o_full),    32'h0);
      check("rst_ovf",     32'(bus.o_ovf),     32'h0);
      check("rst_udf",     32'(bus.o_udf),     32'h0);
      dmp_chk("rst_dmp", 0, 0, 1'b0, 8'h00);

      // T3: simultaneous push/pop on one channel, then on different channels
      push(0, 8'h11);
      check("t3_empty_n0", 32'(bus.o_empty_n), 32'h1);
      bus.i_rd_ch = 2'd0;
      #1;
      check("t3_head11", 32'(bus.o_data), 32'h11);
      bus.i_wr = 1'b1; bus.i_wr_ch = 2'd0; bus.i_data = 8'h22;
      bus.i_rd = 1'b1; bus.i_rd_ch = 2'd0;
      cyc();
      bus.i_wr = 1'b0; bus.i_rd = 1'b0;
      check("t3_head22", 32'(bus.o_data), 32'h22);
      dmp_chk("t3_lvl1_p0", 0, 0, 1'b1, 8'h22);
      dmp_chk("t3_lvl1_p1", 0, 1, 1'b0, 8'h00);
      bus.i_wr = 1'b1; bus.i_wr_ch = 2'd1; bus.i_data = 8'h33;
      bus.i_rd = 1'b1; bus.i_rd_ch = 2'd0;
      cyc();
      bus.i_wr = 1'b0; bus.i_rd = 1'b0;
      check("t3_indep_empty_n", 32'(bus.o_empty_n), 32'h2);
      bus.i_rd_ch = 2'd1;
      #1;
      check("t3_head33", 32'(bus.o_data), 32'h33);
      pop(1);

      // T4: pop of empty ch0 alongside a push to ch0
      bus.i_wr = 1'b1; bus.i_wr_ch = 2'd0; bus.i_data = 8'h7F;
      bus.i_rd = 1'b1; bus.i_rd_ch = 2'd0;
      cyc();
      bus.i_wr = 1'b0; bus.i_rd = 1'b0;
      check("t4_udf", 32'(bus.o_udf), 32'h1);
      check("t4_empty_n", 32'(bus.o_empty_n), 32'h1);
      check("t4_head7f", 32'(bus.o_data), 32'h7F);
      dmp_chk("t4_lvl1", 0, 1, 1'b0, 8'h00);
      bus.i_clr_err = 1'b1;
      cyc();
      bus.i_clr_err = 1'b0;
      check("t4_clr_udf", 32'(bus.o_udf), 32'h0);
      bus.i_clr_err = 1'b1;
      pop(2);
      bus.i_clr_err = 1'b0;
      check("t4_err_beats_clr", 32'(bus.o_udf), 32'h4);
      bus.i_clr_err = 1'b1;
      cyc();
      bus.i_clr_err = 1'b0;
      pop(0);

      // Out-of-range channel index: ignored entirely
      bus.i_wr = 1'b1; bus.i_wr_ch = 2'd3; bus.i_data = 8'hEE;
      bus.i_rd = 1'b1; bus.i_rd_ch = 2'd3;
      cyc();
      bus.i_wr = 1'b0; bus.i_rd = 1'b0;
      check("oor_empty_n", 32'(bus.o_empty_n), 32'h0);
      check("oor_udf",     32'(bus.o_udf),     32'h0);
      check("oor_ovf",     32'(bus.o_ovf),     32'h0);
      check("oor_data",    32'(bus.o_data),    32'h0);

      // T2: fill ch1, overflow, wrap
      for (int i = 0; i < 32; i++) push(1, 8'(i));
      check("t2_full",    32'(bus.o_full),    32'h2);
      check("t2_empty_n", 32'(bus.o_empty_n), 32'h2);
      push(1, 8'h55);
      check("t2_ovf",      32'(bus.o_ovf),  32'h2);
      check("t2_full_ovf", 32'(bus.o_full), 32'h2);
      dmp_chk("t2_tail_kept", 1, 31, 1'b1, 8'h1F);
      bus.i_rd_ch = 2'd1;
      #1;
      check("t2_pop0", 32'(bus.o_data), 32'h00);
      bus.i_wr = 1'b1; bus.i_wr_ch = 2'd1; bus.i_data = 8'h66;
      bus.i_rd = 1'b1;
      cyc();
      bus.i_wr = 1'b0; bus.i_rd = 1'b0;
      check("t2_no_room_full", 32'(bus.o_full), 32'h0);
      dmp_chk("t2_no_room_p30", 1, 30, 1'b1, 8'h1F);
      dmp_chk("t2_no_room_p31", 1, 31, 1'b0, 8'h00);
      for (int i = 1; i < 10; i++) pop_chk("t2_pop_lo", 1, 8'(i));
      for (int i = 0; i < 10; i++) push(1, 8'hA0 + 8'(i));
      check("t2_refull", 32'(bus.o_full), 32'h2);
      for (int i = 10; i < 32; i++) pop_chk("t2_pop_hi", 1, 8'(i));
      for (int i = 0; i < 10; i++) pop_chk("t2_pop_wrap", 1, 8'hA0 + 8'(i));
      check("t2_drained", 32'(bus.o_empty_n), 32'h0);
      bus.i_clr_err = 1'b1;
      cyc();
      bus.i_clr_err = 1'b0;
      check("t2_clr_ovf", 32'(bus.o_ovf), 32'h0);

      // T5: flush ch1 while pushing and popping it
      push(0, 8'hC0);
      push(0, 8'hC1);
      pop(2);
      for (int i = 0; i < 5; i++) push(1, 8'hB0 + 8'(i));
      bus.i_flush = 3'b010;
      bus.i_wr = 1'b1; bus.i_wr_ch = 2'd1; bus.i_data = 8'h99;
      bus.i_rd = 1'b1; bus.i_rd_ch = 2'd1;
      cyc();
      bus.i_flush = '0; bus.i_wr = 1'b0; bus.i_rd = 1'b0;
      check("t5_empty_n", 32'(bus.o_empty_n), 32'h1);
      check("t5_udf_kept", 32'(bus.o_udf), 32'h4);
      check("t5_ovf_kept", 32'(bus.o_ovf), 32'h0);
      dmp_chk("t5_ch1_gone", 1, 0, 1'b0, 8'h00);
      dmp_chk("t5_ch0_p0", 0, 0, 1'b1, 8'hC0);
      dmp_chk("t5_ch0_p1", 0, 1, 1'b1, 8'hC1);
      push(1, 8'h12);
      dmp_chk("t5_ch1_new", 1, 0, 1'b1, 8'h12);
      dmp_chk("t5_ch1_lvl1", 1, 1, 1'b0, 8'h00);
      pop_chk("t5_ch1_head", 1, 8'h12);
      bus.i_clr_err = 1'b1;
      cyc();
      bus.i_clr_err = 1'b0;

      // T6: dump across a wrap in ch0
      bus.i_flush = 3'b001;
      cyc();
      bus.i_flush = '0;
      for (int i = 0; i < 30; i++) begin
         push(0, 8'(i));
         pop(0);
      end
      push(0, 8'hE0);
      push(0, 8'hE1);
      push(0, 8'hE2);
      dmp_chk("t6_p0", 0, 0, 1'b1, 8'hE0);
      dmp_chk("t6_p1", 0, 1, 1'b1, 8'hE1);
      dmp_chk("t6_p2", 0, 2, 1'b1, 8'hE2);
      dmp_chk("t6_p3", 0, 3, 1'b0, 8'h00);
      dmp_chk("t6_oor_ch", 3, 0, 1'b0, 8'h00);

      // T1: async reset mid-traffic, ch0 holding 3 words, ch2 full and overflowed
      for (int i = 0; i < 33; i++) push(2, 8'(i));
      check("t1_pre_full", 32'(bus.o_full), 32'h4);
      check("t1_pre_ovf",  32'(bus.o_ovf),  32'h4);
      pop(1);
      check("t1_pre_udf",  32'(bus.o_udf),  32'h2);
      bus.i_wr = 1'b1; bus.i_wr_ch = 2'd0; bus.i_data = 8'h44;
      bus.i_dmp_ch = 2'd0; bus.i_dmp_pos = '0;
      i_rst = 1'b0;
      #1;
      check("t1_empty_n", 32'(bus.o_empty_n), 32'h0);
      check("t1_full",    32'(bus.o_full),    32'h0);
      check("t1_ovf",     32'(bus.o_ovf),     32'h0);
      check("t1_udf",     32'(bus.o_udf),     32'h0);
      check("t1_dmp_v",   32'(bus.o_dmp_valid), 32'h0);
      bus.i_wr = 1'b0;
      cyc();
      i_rst = 1'b1;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
